// File: rtl/fp_pkg.sv
// Shared definitions for the FloPoCo-format comparator: exception codes,
// opcodes, word-width helper and the canonical NaN encoding.
package fp_pkg;

  localparam logic [1:0] EXC_ZERO = 2'b00;
  localparam logic [1:0] EXC_NORM = 2'b01;
  localparam logic [1:0] EXC_INF  = 2'b10;
  localparam logic [1:0] EXC_NAN  = 2'b11;

  localparam logic [2:0] OP_GT  = 3'd0;
  localparam logic [2:0] OP_GE  = 3'd1;
  localparam logic [2:0] OP_LT  = 3'd2;
  localparam logic [2:0] OP_LE  = 3'd3;
  localparam logic [2:0] OP_EQ  = 3'd4;
  localparam logic [2:0] OP_NE  = 3'd5;
  localparam logic [2:0] OP_MAX = 3'd6;
  localparam logic [2:0] OP_MIN = 3'd7;

  // Two exception bits, one sign bit, then exponent and fraction.
  function automatic int fp_width(input int we, input int wf);
    return we + wf + 3;
  endfunction

  localparam int         DEF_W     = fp_width(11, 14);
  localparam logic [DEF_W-1:0] CANON_NAN = {EXC_NAN, {(DEF_W-2){1'b0}}};

endpackage

// File: rtl/fp_cmp_lane.sv
// Combinational single-lane compare of two FloPoCo floats; ordering is taken
// directly from the encodings, so no subtractor is needed.
module fp_cmp_lane
  import fp_pkg::*;
#(
  parameter  int WE = 11,
  parameter  int WF = 14,
  localparam int W  = fp_width(WE, WF)
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic         flag,
  output logic         unord,
  output logic [W-1:0] val
);

  localparam int KW = W - 1;

  logic [1:0]    exc_a, exc_b;
  logic          sign_a, sign_b;
  logic [KW-1:0] key_a, key_b;
  logic          mag_lt, mag_eq;
  logic          nan_a, nan_b, both_zero;
  logic          is_eq, is_lt, is_gt;
  logic          want_max;

  assign exc_a  = a[W-1 -: 2];
  assign exc_b  = b[W-1 -: 2];
  assign sign_a = a[W-3];
  assign sign_b = b[W-3];

  // Exponent/fraction only carry meaning for normals; zero them otherwise so
  // all zeros, all infinities and all NaNs collapse to one key each.
  assign key_a = {exc_a, (exc_a == EXC_NORM) ? a[W-4:0] : {(W-3){1'b0}}};
  assign key_b = {exc_b, (exc_b == EXC_NORM) ? b[W-4:0] : {(W-3){1'b0}}};

  assign mag_lt    = key_a < key_b;
  assign mag_eq    = key_a == key_b;
  assign nan_a     = exc_a == EXC_NAN;
  assign nan_b     = exc_b == EXC_NAN;
  assign both_zero = (exc_a == EXC_ZERO) && (exc_b == EXC_ZERO);

  assign unord    = nan_a | nan_b;
  assign is_eq    = both_zero | (mag_eq & (sign_a == sign_b));
  assign is_gt    = ~is_lt & ~is_eq;
  assign want_max = op == OP_MAX;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    is_lt = 1'b0;
    if (both_zero)
      is_lt = 1'b0;
    else if (sign_a != sign_b)
      is_lt = sign_a;
    else if (sign_a)
      is_lt = ~mag_lt & ~mag_eq;
    else
      is_lt = mag_lt;
  end

  always_comb begin
    flag = 1'b0;
    val  = a;
    unique case (op)
      OP_GT:   flag = ~unord & is_gt;
      OP_GE:   flag = ~unord & (is_gt | is_eq);
      OP_LT:   flag = ~unord & is_lt;
      OP_LE:   flag = ~unord & (is_lt | is_eq);
      OP_EQ:   flag = ~unord & is_eq;
      OP_NE:   flag = unord | ~is_eq;
      default: begin
        flag = 1'b0;
        if (nan_a && nan_b)
          val = {EXC_NAN, {(W-2){1'b0}}};
        else if (nan_a)
          val = b;
        else if (nan_b)
          val = a;
        else if (is_eq) begin
          // Signed zeros compare equal, yet MAX prefers +0 and MIN prefers -0.
          if (both_zero && (sign_a != sign_b))
            val = (want_max ^ sign_a) ? a : b;
          else
            val = a;
        end else
          val = (want_max == is_gt) ? a : b;
      end
    endcase
  end

endmodule

// File: rtl/fp_compare_pipe.sv
// Multi-lane pipelined FP comparator: lane compares feed STAGES register
// stages sharing one valid/ready handshake with a global stall.
module fp_compare_pipe
  import fp_pkg::*;
#(
  parameter  int WE     = 11,
  parameter  int WF     = 14,
  parameter  int LANES  = 1,
  parameter  int STAGES = 2,
  parameter  int TAG_W  = 4,
  localparam int W      = fp_width(WE, WF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic [LANES*W-1:0] in_a,
  input  logic [LANES*W-1:0] in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES-1:0]   out_flag,
  output logic [LANES-1:0]   out_unord,
  output logic [LANES*W-1:0] out_val,
  output logic [TAG_W-1:0]   out_tag
);

  logic               stall;
  logic [LANES-1:0]   lane_flag;
  logic [LANES-1:0]   lane_unord;
  logic [LANES*W-1:0] lane_val;

  logic               vld_q   [STAGES];
  logic [LANES-1:0]   flag_q  [STAGES];
  logic [LANES-1:0]   unord_q [STAGES];
  logic [LANES*W-1:0] val_q   [STAGES];
  logic [TAG_W-1:0]   tag_q   [STAGES];

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp_cmp_lane #(
      .WE (WE),
      .WF (WF)
    ) u_lane (
      .a     (in_a[i*W +: W]),
      .b     (in_b[i*W +: W]),
      .op    (in_op),
      .flag  (lane_flag[i]),
      .unord (lane_unord[i]),
      .val   (lane_val[i*W +: W])
    );
  end

  // Stage 0 captures the compare result; later stages are pure delay. A stall
  // freezes every stage, and with no stall bubbles simply shift out.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data registers are cleared along with the valids because
      // the outputs must read zero after reset, not just be marked invalid.
      for (int s = 0; s < STAGES; s++) begin
        vld_q[s]   <= 1'b0;
        flag_q[s]  <= '0;
        unord_q[s] <= '0;
        val_q[s]   <= '0;
        tag_q[s]   <= '0;
      end
    end else if (!stall) begin
      // NOTE: non-blocking assignments make each stage read its predecessor's
      // old value, so the shift works regardless of statement order.
      vld_q[0]   <= in_valid;
      flag_q[0]  <= lane_flag;
      unord_q[0] <= lane_unord;
      val_q[0]   <= lane_val;
      tag_q[0]   <= in_tag;
      for (int s = 1; s < STAGES; s++) begin
        vld_q[s]   <= vld_q[s-1];
        flag_q[s]  <= flag_q[s-1];
        unord_q[s] <= unord_q[s-1];
        val_q[s]   <= val_q[s-1];
        tag_q[s]   <= tag_q[s-1];
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_flag  = flag_q[STAGES-1];
  assign out_unord = unord_q[STAGES-1];
  assign out_val   = val_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Self-checking bench: directed vector table plus random traffic through a
// scoreboard, backpressure, mid-flight reset and a 4-lane instance.
module tb_fp_compare_pipe;
  import fp_pkg::*;

  localparam int WE = 11, WF = 14, W = 28, TAG_W = 4, STAGES = 2;

  localparam logic [W-1:0] P1   = 28'h4FFC000;
  localparam logic [W-1:0] P2   = 28'h5000000;
  localparam logic [W-1:0] N1   = 28'h6FFC000;
  localparam logic [W-1:0] N2   = 28'h7000000;
  localparam logic [W-1:0] PZ   = 28'h0000000;
  localparam logic [W-1:0] NZ   = 28'h2000000;
  localparam logic [W-1:0] PINF = 28'h8000000;
  localparam logic [W-1:0] NINF = 28'hA000000;
  localparam logic [W-1:0] QNAN = 28'hC000000;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [2:0]       in_op;
  logic [W-1:0]     in_a, in_b, out_val;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic             out_flag, out_unord;

  logic             in_valid4, in_ready4, out_valid4;
  logic [2:0]       in_op4;
  logic [4*W-1:0]   in_a4, in_b4, out_val4;
  logic [TAG_W-1:0] in_tag4, out_tag4;
  logic [3:0]       out_flag4, out_unord4;

  always #5 clk = ~clk;

  fp_compare_pipe #(.WE(WE), .WF(WF), .LANES(1), .STAGES(STAGES), .TAG_W(TAG_W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_flag(out_flag), .out_unord(out_unord), .out_val(out_val), .out_tag(out_tag)
  );

  fp_compare_pipe #(.WE(WE), .WF(WF), .LANES(4), .STAGES(STAGES), .TAG_W(TAG_W)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_op(in_op4),
    .in_a(in_a4), .in_b(in_b4), .in_tag(in_tag4), .out_valid(out_valid4), .out_ready(1'b1),
    .out_flag(out_flag4), .out_unord(out_unord4), .out_val(out_val4), .out_tag(out_tag4)
  );

  typedef struct {
    logic             flag;
    logic             unord;
    logic [W-1:0]     val;
    logic [TAG_W-1:0] tag;
  } exp_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flag;
    logic         unord;
    logic [W-1:0] val;
  } vec_t;

  exp_t         sb_q[$];
  exp_t         pending;
  vec_t         vecs [18];
  logic [W-1:0] pool [12];
  int           n_checks = 0;
  int           n_errors = 0;
  int           n_out = 0;
  bit           last_acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Order model: map each non-NaN value onto a signed integer line.
  function automatic longint ord(input logic [W-1:0] x);
    longint r;
    case (x[W-1 -: 2])
      2'b00:   r = 0;
      2'b01:   r = longint'(x[W-4:0]) + 1;
      default: r = longint'(1) << 40;
    endcase
    return x[W-3] ? -r : r;
  endfunction

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, b,
                                 input logic [TAG_W-1:0] tag);
    exp_t   e;
    bit     na, nb, u;
    longint oa, ob;
    na = a[W-1 -: 2] == 2'b11;
    nb = b[W-1 -: 2] == 2'b11;
    u  = na || nb;
    oa = ord(a);
    ob = ord(b);
    e.unord = u;
    e.tag   = tag;
    e.val   = a;
    case (op)
      3'd0:    e.flag = !u && (oa > ob);
      3'd1:    e.flag = !u && (oa >= ob);
      3'd2:    e.flag = !u && (oa < ob);
      3'd3:    e.flag = !u && (oa <= ob);
      3'd4:    e.flag = !u && (oa == ob);
      3'd5:    e.flag = u || (oa != ob);
      default: e.flag = 1'b0;
    endcase
    if (op >= 3'd6) begin
      if (na && nb)      e.val = {2'b11, {(W-2){1'b0}}};
      else if (na)       e.val = b;
      else if (nb)       e.val = a;
      else if (oa == ob) begin
        if (oa == 0 && a[W-3] != b[W-3])
          e.val = (op == 3'd6) ? (a[W-3] ? b : a) : (a[W-3] ? a : b);
        else
          e.val = a;
      end
      else if (op == 3'd6) e.val = (oa > ob) ? a : b;
      else                 e.val = (oa < ob) ? a : b;
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rand_fp();
    if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 11)];
    return {2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            11'($urandom_range(1022, 1025)), 14'($urandom_range(0, 3))};
  endfunction

  task automatic set_beat(input logic [2:0] op, input logic [W-1:0] a, b,
                          input logic [TAG_W-1:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    pending  = model(op, a, b, tag);
  endtask

  // One clock: sample handshakes before the edge, score, return at negedge.
  task automatic tick();
    exp_t e;
    last_acc = 1'b0;
    #1;
    if (rst) sb_q.delete();
    else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (sb_q.size() == 0) check("unexpected_beat", 64'(out_valid), 64'(0));
        else begin
          e = sb_q.pop_front();
          check("beat", 64'({out_flag, out_unord, out_val, out_tag}),
                64'({e.flag, e.unord, e.val, e.tag}));
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(pending);
        last_acc = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int idx, cyc, n0, k;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    in_valid4 = 1'b0; in_op4 = '0; in_a4 = '0; in_b4 = '0; in_tag4 = '0;
    pending = '{1'b0, 1'b0, '0, '0};

    vecs[0]  = '{OP_GT,  P2,   P1,   1'b1, 1'b0, P2};
    vecs[1]  = '{OP_LT,  P2,   P1,   1'b0, 1'b0, P2};
    vecs[2]  = '{OP_GT,  N1,   PZ,   1'b0, 1'b0, N1};
    vecs[3]  = '{OP_LT,  N1,   PZ,   1'b1, 1'b0, N1};
    vecs[4]  = '{OP_EQ,  PZ,   NZ,   1'b1, 1'b0, PZ};
    vecs[5]  = '{OP_MIN, PZ,   NZ,   1'b0, 1'b0, NZ};
    vecs[6]  = '{OP_MAX, PINF, P2,   1'b0, 1'b0, PINF};
    vecs[7]  = '{OP_GE,  QNAN, P1,   1'b0, 1'b1, QNAN};
    vecs[8]  = '{OP_NE,  QNAN, P1,   1'b1, 1'b1, QNAN};
    vecs[9]  = '{OP_MAX, QNAN, P1,   1'b0, 1'b1, P1};
    vecs[10] = '{OP_MIN, QNAN, QNAN, 1'b0, 1'b1, QNAN};
    vecs[11] = '{OP_MAX, NZ,   PZ,   1'b0, 1'b0, PZ};
    vecs[12] = '{OP_LE,  P1,   P1,   1'b1, 1'b0, P1};
    vecs[13] = '{OP_GT,  N1,   N2,   1'b1, 1'b0, N1};
    vecs[14] = '{OP_MIN, P1,   NINF, 1'b0, 1'b0, NINF};
    vecs[15] = '{OP_EQ,  28'h0001234, PZ, 1'b1, 1'b0, 28'h0001234};
    vecs[16] = '{OP_EQ,  QNAN, 28'hC00ABCD, 1'b0, 1'b1, QNAN};
    vecs[17] = '{OP_MAX, P1,   P1,   1'b0, 1'b0, P1};

    pool = '{P1, P2, N1, N2, PZ, NZ, PINF, NINF, QNAN, 28'h0001234, 28'hC00ABCD, 28'h8001111};

    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_outputs", 64'({out_flag, out_unord, out_val, out_tag}), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // Back-to-back GT then LT with visible two-cycle latency.
    set_beat(OP_GT, P2, P1, 4'd1);
    tick();
    check("lat_not_yet", 64'(out_valid), 64'(0));
    set_beat(OP_LT, P2, P1, 4'd2);
    tick();
    in_valid = 1'b0;
    check("lat_gt_valid", 64'({out_valid, out_flag, out_unord}), 64'(3'b110));
    tick();
    check("lat_lt_valid", 64'({out_valid, out_flag, out_unord}), 64'(3'b100));
    tick();

    // Directed table, streamed back to back; expectations come from the table.
    for (int i = 0; i < 18; i++) begin
      set_beat(vecs[i].op, vecs[i].a, vecs[i].b, 4'(i));
      pending = '{vecs[i].flag, vecs[i].unord, vecs[i].val, 4'(i)};
      tick();
      check("table_accept", 64'(last_acc), 64'(1));
    end
    in_valid = 1'b0;
    for (k = 0; k < 10 && sb_q.size() != 0; k++) tick();
    check("table_drain", 64'(sb_q.size()), 64'(0));

    // Backpressure: six tagged beats with a three-cycle downstream stall.
    idx = 0; cyc = 0; n0 = n_out;
    while ((idx < 6 || sb_q.size() != 0) && cyc < 40) begin
      in_valid = 1'b0;
      if (idx < 6) set_beat(3'(idx), P2, P1, 4'(idx));
      out_ready = !(cyc >= 3 && cyc < 6);
      if (!out_ready) begin
        #1;
        check("stall_out_valid", 64'(out_valid), 64'(1));
        check("stall_in_ready", 64'(in_ready), 64'(0));
      end
      tick();
      if (last_acc) idx++;
      cyc++;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    check("bp_beats_out", 64'(n_out - n0), 64'(6));
    check("bp_queue_empty", 64'(sb_q.size()), 64'(0));

    // Reset with two beats in flight: nothing may emerge afterwards.
    set_beat(OP_GT, P2, P1, 4'd7); tick();
    set_beat(OP_LT, P2, P1, 4'd8); tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    n0 = n_out;
    for (int i = 0; i < 5; i++) tick();
    check("midrst_no_stale", 64'(n_out - n0), 64'(0));

    // Four lanes, lane 2 compares against NaN.
    in_valid4 = 1'b1;
    in_op4    = OP_GT;
    in_a4     = {P2, P2, P2, P2};
    in_b4     = {P1, QNAN, P1, P1};
    in_tag4   = 4'hA;
    tick();
    in_valid4 = 1'b0;
    k = 1;
    while (!out_valid4 && k < 10) begin
      tick();
      k++;
    end
    check("lanes_valid", 64'(out_valid4), 64'(1));
    check("lanes_latency", 64'(k), 64'(STAGES));
    check("lanes_flag", 64'(out_flag4), 64'(4'b1011));
    check("lanes_unord", 64'(out_unord4), 64'(4'b0100));
    check("lanes_val", 64'(out_val4[3*W +: 16]) ^ 64'(out_val4[W-1:0]), 64'(P2[15:0]) ^ 64'(P2));
    check("lanes_tag", 64'(out_tag4), 64'(4'hA));

    // Random traffic against the order model, with random backpressure.
    idx = 0; cyc = 0;
    while (idx < 300 && cyc < 5000) begin
      in_valid = 1'b0;
      if ($urandom_range(0, 3) != 0) set_beat(3'($urandom_range(0, 7)), rand_fp(), rand_fp(), 4'(idx));
      out_ready = $urandom_range(0, 4) != 0;
      tick();
      if (last_acc) idx++;
      cyc++;
    end
    check("rand_all_sent", 64'(idx), 64'(300));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (k = 0; k < 20 && sb_q.size() != 0; k++) tick();
    check("rand_drain", 64'(sb_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
